clic_irq_scan: RTL and testbench
================================

CLIC_IRQ_SCAN -- requirements
Module: clic_irq_scan

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty: supplies CLICNumInterruptSrc (NumSrc, 256 in the CLIC configuration).
REQ-002 Parameter Lanes, default 8: sources examined per scan cycle; NumSrc SHALL be a power of two and a multiple of Lanes (elaboration assertion).
REQ-003 Parameter LvlW, default 8: interrupt level width.
REQ-004 clk_i  in  1  core clock; single clock domain.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 pending_i  in  NumSrc  per-source pending flag from the CLIC gateway.
REQ-007 enable_i  in  NumSrc  per-source enable (clicintie).
REQ-008 level_i  in  NumSrc*LvlW  per-source level; source k occupies bits [k*LvlW +: LvlW].
REQ-009 thresh_i  in  LvlW  effective threshold, i.e. max(mintthresh, current mil).
REQ-010 irq_valid_o  out  1  candidate interrupt offered to the CSR/controller stage.
REQ-011 irq_ready_i  in  1  controller accepts the candidate.
REQ-012 irq_id_o  out  $clog2(NumSrc)  ID of the offered source.
REQ-013 irq_level_o  out  LvlW  level of the offered source.

Function
REQ-014 The FSM SHALL have exactly two states, SCAN and HOLD; reset state is SCAN with ptr=0.
REQ-015 In SCAN, each cycle SHALL examine sources ptr*Lanes .. ptr*Lanes+Lanes-1; a source is eligible iff pending & enable.
REQ-016 The running best SHALL be replaced only by an eligible source with a strictly greater level; ties therefore resolve to the lowest ID. Within-lane reduction follows the same rule.
REQ-017 ptr SHALL increment each SCAN cycle and wrap from NumSrc/Lanes-1 to 0; the best-found flag, best ID and best level SHALL clear at each wrap.
REQ-018 On the last SCAN cycle (ptr = NumSrc/Lanes-1), if a best exists (including the current lanes) and best level > thresh_i, the FSM SHALL enter HOLD; otherwise it SHALL stay in SCAN with a fresh pass.
REQ-019 Latency: a full pass takes NumSrc/Lanes cycles (32 by default); irq_valid_o SHALL assert in the cycle after the last SCAN cycle.
REQ-020 In HOLD, irq_valid_o=1; irq_id_o and irq_level_o SHALL remain stable until handshake or withdrawal.
REQ-021 Handshake (valid & ready) SHALL move the FSM to SCAN with ptr=0 and the best cleared; irq_valid_o=0 in the next cycle.
REQ-022 Withdrawal: in HOLD without ready, if the held source's pending_i or enable_i is 0, or thresh_i >= the held level, the FSM SHALL deassert valid next cycle and restart SCAN at ptr=0.
REQ-023 Handshake and withdrawal in the same cycle: the handshake wins (counts as accepted).
REQ-024 Higher-level arrivals during HOLD SHALL NOT preempt the held candidate; they are found on the next pass.
REQ-025 Outside HOLD, irq_valid_o=0, and irq_id_o and irq_level_o SHALL be driven to 0.
REQ-026 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-027 While rst_ni=0: state=SCAN, ptr=0, best cleared, irq_valid_o=0, irq_id_o=0, irq_level_o=0.
REQ-028 Reset asserted mid-HOLD SHALL drop valid asynchronously; after release the first scan begins at ptr=0.

Structure
REQ-029 scan_state_e and the default Lanes/LvlW constants SHALL reside in the shared CLIC package, alongside the cva6_cfg fields.
REQ-030 One sub-module, clic_lane_max, SHALL provide the Lanes-wide combinational max/lowest-ID reduction; the FSM, pointer and best registers SHALL live in clic_irq_scan.

Verification
REQ-031 Source 37 pending+enabled, level 0x40, thresh 0x10 -> valid at cycle 32 after reset release; id=37, level=0x40.
REQ-032 Sources 5 and 200 both pending at level 0x80, thresh 0 -> id=5 is offered; after handshake with 5 cleared, the next offer is id=200 exactly 32 cycles later.
REQ-033 Source 9 pending at level 0x20 with thresh 0x20 -> valid is never asserted over 4 passes; lowering thresh to 0x1F -> offer within 2 passes.
REQ-034 HOLD on id 12 with ready=0, then pending_i[12] dropped -> valid=0 next cycle and a rescan from ptr=0; if nothing is eligible, no offer.
REQ-035 HOLD on id 3 at level 0x30, source 100 raised at level 0xF0 while ready=0 for 10 cycles -> id 3 stays stable; after handshake, id 100 is offered 32 cycles later.
REQ-036 rst_ni pulsed low for 1 cycle during HOLD -> valid=0 immediately; after release the same source is re-offered 32 cycles later.

Source files
------------

// File: rtl/clic_irq_scan_pkg.sv
// Shared CLIC definitions: core configuration record, scan FSM states and
// default geometry for the time-multiplexed interrupt arbiter.
package clic_irq_scan_pkg;

  typedef struct packed {
    int unsigned CLICNumInterruptSrc;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{CLICNumInterruptSrc: 256};

  localparam int unsigned DefaultLanes = 8;
  localparam int unsigned DefaultLvlW  = 8;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clic_lane_max.sv
// Combinational reduction over one scan window: highest level wins, ties go
// to the lowest lane index.
module clic_lane_max
  import clic_irq_scan_pkg::*;
#(
  parameter int unsigned Lanes = DefaultLanes,
  parameter int unsigned LvlW  = DefaultLvlW,
  localparam int unsigned IdxW = idxWidth(Lanes)
) (
  input  logic [Lanes-1:0]      eligible_i,
  input  logic [Lanes*LvlW-1:0] level_i,
  output logic                  found_o,
  output logic [IdxW-1:0]       idx_o,
  output logic [LvlW-1:0]       level_o
);

  // Ascending walk with a strict compare keeps the earliest lane on a tie.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    level_o = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (eligible_i[i] && (!found_o || (level_i[i*LvlW +: LvlW] > level_o))) begin
        found_o = 1'b1;
        idx_o   = IdxW'(i);
        level_o = level_i[i*LvlW +: LvlW];
      end
    end
  end

endmodule

// File: rtl/clic_irq_scan.sv
// CLIC interrupt selector: sweeps all sources Lanes at a time, keeps the
// best candidate per pass and holds it towards the controller until taken.
module clic_irq_scan
  import clic_irq_scan_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned Lanes   = DefaultLanes,
  parameter int unsigned LvlW    = DefaultLvlW,
  localparam int unsigned NumSrc = CVA6Cfg.CLICNumInterruptSrc,
  localparam int unsigned IdW    = idxWidth(NumSrc)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumSrc-1:0]        pending_i,
  input  logic [NumSrc-1:0]        enable_i,
  input  logic [NumSrc*LvlW-1:0]   level_i,
  input  logic [LvlW-1:0]          thresh_i,
  output logic                     irq_valid_o,
  input  logic                     irq_ready_i,
  output logic [IdW-1:0]           irq_id_o,
  output logic [LvlW-1:0]          irq_level_o
);

  localparam int unsigned NumWin   = (Lanes == 0) ? 1 : NumSrc / Lanes;
  localparam int unsigned PtrW     = idxWidth(NumWin);
  localparam int unsigned LaneIdxW = idxWidth(Lanes);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NumWin - 1);

  if ((Lanes == 0) || (NumSrc == 0) || ((NumSrc & (NumSrc - 1)) != 0) ||
      ((NumSrc % Lanes) != 0)) begin : g_cfg_check
    $error("clic_irq_scan: NumSrc must be a power of two and a multiple of Lanes");
  end

  scan_state_e      state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic             bestFound_q, bestFound_d;
  logic [IdW-1:0]   bestId_q, bestId_d;
  logic [LvlW-1:0]  bestLvl_q, bestLvl_d;
  logic [IdW-1:0]   outId_q, outId_d;
  logic [LvlW-1:0]  outLvl_q, outLvl_d;

  int unsigned          winBase;
  logic [Lanes-1:0]     laneElig;
  logic                 laneFound;
  logic [LaneIdxW-1:0]  laneIdx;
  logic [LvlW-1:0]      laneLvl;
  logic [IdW-1:0]       laneId;
  logic                 takeLane;
  logic                 mergedFound;
  logic [IdW-1:0]       mergedId;
  logic [LvlW-1:0]      mergedLvl;
  logic                 heldGone;

  assign winBase  = 32'(ptr_q) * Lanes;
  assign laneElig = pending_i[winBase +: Lanes] & enable_i[winBase +: Lanes];

  clic_lane_max #(
    .Lanes (Lanes),
    .LvlW  (LvlW)
  ) u_lane_max (
    .eligible_i (laneElig),
    .level_i    (level_i[winBase*LvlW +: Lanes*LvlW]),
    .found_o    (laneFound),
    .idx_o      (laneIdx),
    .level_o    (laneLvl)
  );

  // Window IDs are always above the running best, so a tie keeps the best.
  assign laneId      = IdW'(winBase) + IdW'(laneIdx);
  assign takeLane    = laneFound && (!bestFound_q || (laneLvl > bestLvl_q));
  assign mergedFound = bestFound_q || laneFound;
  assign mergedId    = takeLane ? laneId  : bestId_q;
  assign mergedLvl   = takeLane ? laneLvl : bestLvl_q;

  assign heldGone = !pending_i[outId_q] || !enable_i[outId_q] || (thresh_i >= outLvl_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bestFound_d = bestFound_q;
    bestId_d    = bestId_q;
    bestLvl_d   = bestLvl_q;
    outId_d     = outId_q;
    outLvl_d    = outLvl_q;
    case (state_q)
      SCAN: begin
        if (ptr_q == LastPtr) begin
          ptr_d       = '0;
          bestFound_d = 1'b0;
          bestId_d    = '0;
          bestLvl_d   = '0;
          if (mergedFound && (mergedLvl > thresh_i)) begin
            state_d  = HOLD;
            outId_d  = mergedId;
            outLvl_d = mergedLvl;
          end
        end else begin
          ptr_d       = ptr_q + 1'b1;
          bestFound_d = mergedFound;
          bestId_d    = mergedId;
          bestLvl_d   = mergedLvl;
        end
      end
      HOLD: begin
        // Acceptance takes priority; either way the next pass starts clean.
        if (irq_ready_i || heldGone) begin
          state_d  = SCAN;
          outId_d  = '0;
          outLvl_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN;
      ptr_q       <= '0;
      bestFound_q <= 1'b0;
      bestId_q    <= '0;
      bestLvl_q   <= '0;
      outId_q     <= '0;
      outLvl_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bestFound_q <= bestFound_d;
      bestId_q    <= bestId_d;
      bestLvl_q   <= bestLvl_d;
      outId_q     <= outId_d;
      outLvl_q    <= outLvl_d;
    end
  end

  assign irq_valid_o = (state_q == HOLD);
  assign irq_id_o    = outId_q;
  assign irq_level_o = outLvl_q;

endmodule

// File: tb/tb_clic_irq_scan.sv
// Self-checking bench for clic_irq_scan: pass-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_clic_irq_scan;
  import clic_irq_scan_pkg::*;

  localparam int NumSrc = 256;
  localparam int Lanes  = 8;
  localparam int LvlW   = 8;
  localparam int IdW    = 8;
  localparam int NumWin = NumSrc / Lanes;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NumSrc-1:0]      pending;
  logic [NumSrc-1:0]      enable;
  logic [NumSrc*LvlW-1:0] level;
  logic [LvlW-1:0]        thresh;
  logic                   ready;
  logic                   irqValid;
  logic [IdW-1:0]         irqId;
  logic [LvlW-1:0]        irqLvl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clic_irq_scan #(
    .CVA6Cfg (cva6_cfg_empty),
    .Lanes   (Lanes),
    .LvlW    (LvlW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pending_i   (pending),
    .enable_i    (enable),
    .level_i     (level),
    .thresh_i    (thresh),
    .irq_valid_o (irqValid),
    .irq_ready_i (ready),
    .irq_id_o    (irqId),
    .irq_level_o (irqLvl)
  );

  // Reference: a pass is NumWin cycles; at its end the whole source array is
  // searched for the highest eligible level (lowest ID on ties).
  bit mHold = 1'b0;
  int mCnt  = 0;
  int mId   = 0;
  int mLvl  = 0;
  bit pf;
  int pid;
  int plvl;

  function automatic void bestOf(output bit f, output int id, output int lvl);
    int l;
    f = 1'b0; id = 0; lvl = 0;
    for (int k = 0; k < NumSrc; k++) begin
      if (pending[k] && enable[k]) begin
        l = int'(level[k*LvlW +: LvlW]);
        if (!f || l > lvl) begin
          f = 1'b1; id = k; lvl = l;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHold = 1'b0; mCnt = 0; mId = 0; mLvl = 0;
    end else if (!mHold) begin
      if (mCnt == NumWin - 1) begin
        mCnt = 0;
        bestOf(pf, pid, plvl);
        if (pf && plvl > int'(thresh)) begin
          mHold = 1'b1; mId = pid; mLvl = plvl;
        end
      end else begin
        mCnt++;
      end
    end else if (ready || !pending[mId] || !enable[mId] || int'(thresh) >= mLvl) begin
      mHold = 1'b0; mCnt = 0; mId = 0; mLvl = 0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (irqValid !== mHold || irqId !== IdW'(mId) || irqLvl !== LvlW'(mLvl)) begin
      errors++;
      $display("[TB] FAIL model_cmp t=%0t: got v=%0b id=%0d lvl=%0h, want v=%0b id=%0d lvl=%0h",
               $time, irqValid, irqId, irqLvl, mHold, mId, mLvl);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expV, input int expId, input int expLvl);
    checks++;
    if (irqValid !== expV || irqId !== IdW'(expId) || irqLvl !== LvlW'(expLvl)) begin
      errors++;
      $display("[TB] FAIL %s: got v=%0b id=%0d lvl=%0h, want v=%0b id=%0d lvl=%0h",
               name, irqValid, irqId, irqLvl, expV, expId, expLvl);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(input int id, input int lvl);
    pending[id] = 1'b1;
    enable[id]  = 1'b1;
    level[id*LvlW +: LvlW] = LvlW'(lvl);
  endtask

  task automatic startReset();
    rst_n   = 1'b0;
    ready   = 1'b0;
    thresh  = '0;
    pending = '0;
    enable  = '0;
    level   = '0;
  endtask

  task automatic releaseReset();
    cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic countValid(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < n; c++) begin
      cycles(1);
      if (irqValid === 1'b1) seen++;
    end
  endtask

  task automatic waitOffer(input int maxCyc, input string name, output int taken);
    taken = -1;
    for (int c = 1; c <= maxCyc; c++) begin
      cycles(1);
      if (irqValid === 1'b1) begin
        taken = c;
        break;
      end
    end
    checks++;
    if (taken < 0) begin
      errors++;
      $display("[TB] FAIL %s: got no offer in %0d cycles, want an offer", name, maxCyc);
    end
  endtask

  task automatic handshake();
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
  endtask

  initial begin
    int n;
    int taken;
    ready = 1'b0; thresh = '0; pending = '0; enable = '0; level = '0;
    #1 rst_n = 1'b0;
    cycles(2);
    checkOutput("reset_idle", 1'b0, 0, 0);

    $display("[TB] single source, fixed latency");
    thresh = 8'h10;
    applyStimulus(37, 'h40);
    cycles(2);
    checkOutput("reset_with_pending", 1'b0, 0, 0);
    rst_n = 1'b1;
    cycles(31);
    checkOutput("t1_not_early", 1'b0, 0, 0);
    cycles(1);
    checkOutput("t1_offer_37", 1'b1, 37, 'h40);
    cycles(3);
    checkOutput("t1_stable", 1'b1, 37, 'h40);
    handshake();
    checkOutput("t1_after_handshake", 1'b0, 0, 0);

    $display("[TB] equal levels, lowest ID first");
    startReset();
    applyStimulus(5, 'h80);
    applyStimulus(200, 'h80);
    releaseReset();
    cycles(32);
    checkOutput("t2_offer_5", 1'b1, 5, 'h80);
    pending[5] = 1'b0;
    handshake();
    checkOutput("t2_handshake", 1'b0, 0, 0);
    cycles(31);
    checkOutput("t2_not_early", 1'b0, 0, 0);
    cycles(1);
    checkOutput("t2_offer_200", 1'b1, 200, 'h80);

    $display("[TB] threshold boundary");
    startReset();
    applyStimulus(9, 'h20);
    thresh = 8'h20;
    releaseReset();
    countValid(4 * NumWin, n);
    checkCount("t3_no_offer_at_thresh", n, 0);
    thresh = 8'h1F;
    waitOffer(2 * NumWin, "t3_offer_below_thresh", taken);
    checkOutput("t3_offer_9", 1'b1, 9, 'h20);

    $display("[TB] withdrawal");
    startReset();
    applyStimulus(12, 'h50);
    releaseReset();
    cycles(32);
    checkOutput("t4_hold_12", 1'b1, 12, 'h50);
    cycles(3);
    checkOutput("t4_hold_stable", 1'b1, 12, 'h50);
    pending[12] = 1'b0;
    cycles(1);
    checkOutput("t4_withdraw_pending", 1'b0, 0, 0);
    pending[12] = 1'b1;
    cycles(31);
    checkOutput("t4_rescan_not_early", 1'b0, 0, 0);
    cycles(1);
    checkOutput("t4_rescan_from_zero", 1'b1, 12, 'h50);
    enable[12] = 1'b0;
    cycles(1);
    checkOutput("t4_withdraw_enable", 1'b0, 0, 0);
    countValid(2 * NumWin, n);
    checkCount("t4_nothing_eligible", n, 0);
    startReset();
    applyStimulus(12, 'h50);
    releaseReset();
    cycles(32);
    checkOutput("t4_hold_again", 1'b1, 12, 'h50);
    thresh = 8'h50;
    cycles(1);
    checkOutput("t4_withdraw_thresh", 1'b0, 0, 0);

    $display("[TB] no preemption while held");
    startReset();
    applyStimulus(3, 'h30);
    releaseReset();
    cycles(32);
    checkOutput("t5_hold_3", 1'b1, 3, 'h30);
    applyStimulus(100, 'hF0);
    cycles(10);
    checkOutput("t5_no_preempt", 1'b1, 3, 'h30);
    handshake();
    checkOutput("t5_handshake", 1'b0, 0, 0);
    cycles(31);
    checkOutput("t5_not_early", 1'b0, 0, 0);
    cycles(1);
    checkOutput("t5_offer_100", 1'b1, 100, 'hF0);

    $display("[TB] reset during hold");
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_drop", 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(31);
    checkOutput("t6_not_early", 1'b0, 0, 0);
    cycles(1);
    checkOutput("t6_reoffer_100", 1'b1, 100, 'hF0);

    $display("[TB] tie inside one window");
    startReset();
    applyStimulus(17, 'h70);
    applyStimulus(18, 'h70);
    applyStimulus(250, 'h60);
    releaseReset();
    cycles(32);
    checkOutput("t7_offer_17", 1'b1, 17, 'h70);
    pending[17] = 1'b0;
    handshake();
    cycles(32);
    checkOutput("t7_offer_18", 1'b1, 18, 'h70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
